accumulateur_32bit: RTL and testbench

ACCUMULATEUR_32BIT -- requirements
Module: accumulateur_32bit

---
 rtl/accumulateur_32bit_pkg.sv | 23 ++
 rtl/accumulateur_32bit_additionneur.sv | 16 +
 rtl/accumulateur_32bit.sv | 113 +++++++++++
 tb/tb_accumulateur_32bit.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/accumulateur_32bit_pkg.sv
`default_nettype none
// ============================================================================
// accumulateur_32bit_pkg : state encodings and saturation limits shared by the
//                          accumulator stages.            Revision 1.0
// ============================================================================
package accumulateur_32bit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_ACCUM = 2'b01,
    ST_DONE  = 2'b10
  } acc_state_e;

  localparam logic [31:0] SAT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] SAT_MIN = 32'h8000_0000;

  // Saturation bound selected by the common sign of the overflowing operands.
  function automatic logic [31:0] sat_value(input logic neg_operands);
    return neg_operands ? SAT_MIN : SAT_MAX;
  endfunction

endpackage
`default_nettype wire

// File: rtl/accumulateur_32bit_additionneur.sv
`default_nettype none
// ============================================================================
// additionneur_32bit : 32-bit two's-complement adder with carry-in.
//                                                         Revision 1.0
// ============================================================================
module additionneur_32bit (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        rin_i,
  output logic [31:0] s_o
);

  assign s_o = a_i + b_i + {31'b0, rin_i};

endmodule
`default_nettype wire

// File: rtl/accumulateur_32bit.sv
`default_nettype none
// ============================================================================
// accumulateur_32bit : saturating signed accumulator, bias + N_TERMS terms
//                      per sample, valid/ready on both sides.  Revision 1.0
// ============================================================================
module accumulateur_32bit
  import accumulateur_32bit_pkg::*;
#(
  parameter int N_TERMS = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] bias,
  input  logic [31:0] term_data,
  input  logic        term_valid,
  output logic        term_ready,
  output logic [31:0] y_data,
  output logic        y_valid,
  input  logic        y_ready,
  output logic        y_ovf,
  output logic        busy
);

  localparam int            CW   = $clog2(N_TERMS) + 1;
  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] LAST = CW'(N_TERMS);

  acc_state_e    state_q, state_d;
  logic [31:0]   acc_q, acc_d;
  logic [CW-1:0] count_q, count_d;
  logic          ovf_q, ovf_d;

  logic          term_hs;
  logic [31:0]   op_a;
  logic [31:0]   sum;
  logic          add_ovf;
  logic [31:0]   sat_sum;

  // Handshake outputs come from registered state only, never from the inputs.
  assign term_ready = (state_q != ST_DONE);
  assign y_valid    = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign y_data     = acc_q;
  assign y_ovf      = ovf_q;

  assign term_hs = term_valid & term_ready;

  // The first term of a sample adds onto the bias, later ones onto acc.
  assign op_a = (state_q == ST_IDLE) ? bias : acc_q;

  additionneur_32bit u_add (
    .a_i   (op_a),
    .b_i   (term_data),
    .rin_i (1'b0),
    .s_o   (sum)
  );

  assign add_ovf = (op_a[31] == term_data[31]) && (sum[31] != op_a[31]);
  assign sat_sum = add_ovf ? sat_value(op_a[31]) : sum;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE: begin
        if (term_hs) begin
          acc_d   = sat_sum;
          ovf_d   = add_ovf;
          count_d = ONE;
          state_d = (N_TERMS == 1) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (term_hs) begin
          acc_d   = sat_sum;
          ovf_d   = ovf_q | add_ovf;
          count_d = count_q + ONE;
          if (count_d == LAST) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        if (y_ready) begin
          state_d = ST_IDLE;
          count_d = '0;
          ovf_d   = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_accumulateur_32bit.sv
`default_nettype none
// ============================================================================
// tb_accumulateur_32bit : directed vectors for N_TERMS = 4, 2 and 1 instances.
//                                                         Revision 1.0
// ============================================================================
module tb_accumulateur_32bit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] bias_s [3];
  logic [31:0] td_s   [3];
  logic        tv_s   [3];
  logic        tr_s   [3];
  logic [31:0] yd_s   [3];
  logic        yv_s   [3];
  logic        yr_s   [3];
  logic        yo_s   [3];
  logic        busy_s [3];

  always #5 clk = ~clk;

  accumulateur_32bit #(.N_TERMS(4)) u_n4 (
    .clk(clk), .rst_n(rst_n), .bias(bias_s[0]), .term_data(td_s[0]),
    .term_valid(tv_s[0]), .term_ready(tr_s[0]), .y_data(yd_s[0]),
    .y_valid(yv_s[0]), .y_ready(yr_s[0]), .y_ovf(yo_s[0]), .busy(busy_s[0])
  );

  accumulateur_32bit #(.N_TERMS(2)) u_n2 (
    .clk(clk), .rst_n(rst_n), .bias(bias_s[1]), .term_data(td_s[1]),
    .term_valid(tv_s[1]), .term_ready(tr_s[1]), .y_data(yd_s[1]),
    .y_valid(yv_s[1]), .y_ready(yr_s[1]), .y_ovf(yo_s[1]), .busy(busy_s[1])
  );

  accumulateur_32bit #(.N_TERMS(1)) u_n1 (
    .clk(clk), .rst_n(rst_n), .bias(bias_s[2]), .term_data(td_s[2]),
    .term_valid(tv_s[2]), .term_ready(tr_s[2]), .y_data(yd_s[2]),
    .y_valid(yv_s[2]), .y_ready(yr_s[2]), .y_ovf(yo_s[2]), .busy(busy_s[2])
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  typedef struct {
    int               inst;
    logic [31:0]      bias;
    logic [3:0][31:0] terms;
    int               n;
    logic [31:0]      exp_y;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs [11];

  // Back-to-back terms with y_ready high; bias is corrupted after the first
  // handshake to show it is only sampled once.
  task automatic run_sample(input int k, input logic [31:0] b, input logic [3:0][31:0] t,
                            input int n, input logic [31:0] exp_y, input logic exp_ovf,
                            input string name);
    @(negedge clk);
    bias_s[k] = b;
    yr_s[k]   = 1'b1;
    for (int i = 0; i < n; i++) begin
      td_s[k] = t[i];
      tv_s[k] = 1'b1;
      chk1({name, " term_ready"}, tr_s[k], 1'b1);
      chk1({name, " y_valid early"}, yv_s[k], 1'b0);
      @(posedge clk);
      #1;
      if (i == 0) bias_s[k] = 32'hDEAD_BEEF;
    end
    tv_s[k] = 1'b0;
    td_s[k] = '0;
    chk1({name, " y_valid"}, yv_s[k], 1'b1);
    chk ({name, " y_data"}, yd_s[k], exp_y);
    chk1({name, " y_ovf"}, yo_s[k], exp_ovf);
    chk1({name, " busy"}, busy_s[k], 1'b1);
    chk1({name, " term_ready done"}, tr_s[k], 1'b0);
    @(posedge clk);
    #1;
    chk1({name, " y_valid after hs"}, yv_s[k], 1'b0);
    chk1({name, " busy after hs"}, busy_s[k], 1'b0);
  endtask

  initial begin
    vecs[0]  = '{0, 32'h0000_000A, {32'd4, 32'd3, 32'd2, 32'd1}, 4, 32'h0000_0014, 1'b0};
    vecs[1]  = '{0, 32'h7FFF_FFFF, {32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1}, 4, 32'h7FFF_FFFD, 1'b1};
    vecs[2]  = '{0, 32'h8000_0000, {32'h0, 32'h0, 32'h5, 32'hFFFF_FFFF}, 4, 32'h8000_0005, 1'b1};
    vecs[3]  = '{0, 32'hFFFF_FFF9, {32'd3, 32'd3, 32'd3, 32'd3}, 4, 32'h0000_0005, 1'b0};
    vecs[4]  = '{1, 32'h7FFF_FFF0, {32'h0, 32'h0, 32'hFFFF_FFF0, 32'h20}, 2, 32'h7FFF_FFEF, 1'b1};
    vecs[5]  = '{1, 32'h4000_0000, {32'h0, 32'h0, 32'h8000_0000, 32'h4000_0000}, 2, 32'hFFFF_FFFF, 1'b1};
    vecs[6]  = '{1, 32'h0000_0064, {32'h0, 32'h0, 32'hFFFF_FFC4, 32'hFFFF_FFCE}, 2, 32'hFFFF_FFF6, 1'b0};
    vecs[7]  = '{2, 32'h8000_0000, {32'h0, 32'h0, 32'h0, 32'hFFFF_FFFF}, 1, 32'h8000_0000, 1'b1};
    vecs[8]  = '{2, 32'h0000_0003, {32'h0, 32'h0, 32'h0, 32'h4}, 1, 32'h0000_0007, 1'b0};
    vecs[9]  = '{2, 32'h7FFF_FFFF, {32'h0, 32'h0, 32'h0, 32'h8000_0000}, 1, 32'hFFFF_FFFF, 1'b0};
    vecs[10] = '{0, 32'h8000_0000, {32'h1, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000}, 4, 32'h0000_0001, 1'b1};

    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      bias_s[k] = '0;
      td_s[k]   = '0;
      tv_s[k]   = 1'b0;
      yr_s[k]   = 1'b0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      chk ("reset y_data", yd_s[k], 32'h0);
      chk1("reset y_valid", yv_s[k], 1'b0);
      chk1("reset y_ovf", yo_s[k], 1'b0);
      chk1("reset busy", busy_s[k], 1'b0);
      chk1("reset term_ready", tr_s[k], 1'b1);
    end
    rst_n = 1'b1;

    for (int v = 0; v < 11; v++) begin
      run_sample(vecs[v].inst, vecs[v].bias, vecs[v].terms, vecs[v].n,
                 vecs[v].exp_y, vecs[v].exp_ovf, $sformatf("vec%0d", v));
    end

    // Terms offered every other cycle; idle cycles carry junk data.
    @(negedge clk);
    bias_s[0] = 32'hFFFF_FFFB;
    yr_s[0]   = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tv_s[0] = 1'b1;
      td_s[0] = 32'hFFFF_FFFF;
      @(posedge clk);
      #1;
      if (i == 0) bias_s[0] = 32'h0000_1234;
      if (i < 3) begin
        tv_s[0] = 1'b0;
        td_s[0] = 32'd1000;
        chk1("toggle y_valid early", yv_s[0], 1'b0);
        @(posedge clk);
        #1;
      end
    end
    tv_s[0] = 1'b0;
    chk1("toggle y_valid", yv_s[0], 1'b1);
    chk ("toggle y_data", yd_s[0], 32'hFFFF_FFF7);
    chk1("toggle y_ovf", yo_s[0], 1'b0);
    @(posedge clk);
    #1;

    // Result held with y_ready low while terms keep being offered.
    bias_s[0] = 32'h0;
    yr_s[0]   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tv_s[0] = 1'b1;
      td_s[0] = 32'd1;
      @(posedge clk);
      #1;
    end
    td_s[0] = 32'd77;
    for (int c = 0; c < 5; c++) begin
      chk1("stall y_valid", yv_s[0], 1'b1);
      chk ("stall y_data", yd_s[0], 32'd4);
      chk1("stall term_ready", tr_s[0], 1'b0);
      @(posedge clk);
      #1;
    end
    tv_s[0] = 1'b0;
    yr_s[0] = 1'b1;
    @(posedge clk);
    #1;
    chk1("stall release y_valid", yv_s[0], 1'b0);
    chk1("stall release busy", busy_s[0], 1'b0);
    run_sample(0, 32'd2, {32'd1, 32'd1, 32'd1, 32'd1}, 4, 32'd6, 1'b0, "after_stall");

    // Asynchronous reset after two of four terms.
    @(negedge clk);
    bias_s[0] = 32'd9;
    for (int i = 0; i < 2; i++) begin
      tv_s[0] = 1'b1;
      td_s[0] = 32'd1;
      @(posedge clk);
      #1;
    end
    tv_s[0] = 1'b0;
    chk1("mid busy", busy_s[0], 1'b1);
    rst_n = 1'b0;
    #1;
    chk1("async busy", busy_s[0], 1'b0);
    chk1("async y_valid", yv_s[0], 1'b0);
    chk ("async y_data", yd_s[0], 32'h0);
    chk1("async term_ready", tr_s[0], 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    run_sample(0, 32'd1, {32'd1, 32'd1, 32'd1, 32'd1}, 4, 32'd5, 1'b0, "after_reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
